// File: rtl/urs_pio_word_shifter.sv
// ---------------------------------------------------------------------------
// urs_pio_word_shifter
//
// Watches the PIO out_port word and queues every value change in a small
// FIFO. Each queued word is shifted out MSB-first on a three-wire serial link
// (sclk / sdata / sload) to an off-chip shift register with output latch.
// Software can update the PIO at full bus speed while the slow link drains
// at its own rate.
//
// Parameters:
//   WIDTH      - word width, must match the PIO out_port width
//   CLK_DIV    - clk cycles per sclk half-period (>= 1)
//   FIFO_DEPTH - number of queued words (power of two, >= 2)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   pio_word  in   PIO out_port value
//   ovf_clr   in   one-cycle pulse, clears overflow
//   sclk      out  serial clock, idles low
//   sdata     out  serial data, MSB first, held for a full bit time
//   sload     out  latch strobe after the last bit, CLK_DIV cycles
//   busy      out  registered: FSM not idle or FIFO non-empty
//   overflow  out  sticky: a change was dropped because the FIFO was full
//
// Optional feature (compile-time macro URS_SHIFT_PARITY_EN):
//   When defined, one even-parity bit (XOR of all data bits) is appended
//   after the LSB, before the latch strobe. When undefined no parity logic
//   exists.
// ---------------------------------------------------------------------------
module urs_pio_word_shifter #(
    parameter int WIDTH      = 14,
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pio_word,
    input  logic             ovf_clr,
    output logic             sclk,
    output logic             sdata,
    output logic             sload,
    output logic             busy,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef URS_SHIFT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BCW = $clog2(WIDTH + 1);
    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0]  PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BC_LOAD = BCW'(NBITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             sclk_q, sclk_d;
    logic             busy_q;
    logic             overflow_q, overflow_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             change;
    logic             pop;
    logic             push_ok;
    logic             ovf_evt;
    logic [WIDTH-1:0] rd_data;
    logic [NBITS-1:0] load_word;

    // ------------------------------------------------------------------
    // Change detect and FIFO control
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign change  = (pio_word != prev_q);
    assign pop     = (state_q == ST_IDLE) && !fifo_empty;
    // A pop on the same cycle frees a slot, so a push into a full FIFO is
    // still accepted in that case.
    assign push_ok = change && (!fifo_full || pop);
    assign ovf_evt = change && fifo_full && !pop;

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

`ifdef URS_SHIFT_PARITY_EN
    assign load_word = {rd_data, ^rd_data};
`else
    assign load_word = rd_data;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Set wins over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Storage array has no reset so it maps onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= pio_word;
        end
    end

    // ------------------------------------------------------------------
    // Serial FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        sclk_d    = sclk_q;

        unique case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                if (!fifo_empty) begin
                    shreg_d   = load_word;
                    bit_cnt_d = BC_LOAD;
                    phase_d   = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        // End of low half: raise sclk, data stays put.
                        sclk_d = 1'b1;
                    end else begin
                        // End of high half: bit finished.
                        sclk_d = 1'b0;
                        if (bit_cnt_q == '0) begin
                            state_d = ST_LATCH;
                        end else begin
                            shreg_d   = shreg_q << 1;
                            bit_cnt_d = bit_cnt_q - BCW'(1);
                        end
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            ST_LATCH: begin
                sclk_d = 1'b0;
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= '0;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // prev_q tracks the input even when the push is dropped.
            if (change) begin
                prev_q <= pio_word;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            sclk_q     <= sclk_d;
            // Registered from current state: rises the cycle after a push,
            // falls the cycle after LATCH ends with nothing queued.
            busy_q     <= (state_q != ST_IDLE) || !fifo_empty;
            overflow_q <= overflow_d;
        end
    end

    assign sclk     = sclk_q;
    assign sdata    = (state_q == ST_SHIFT) && shreg_q[NBITS-1];
    assign sload    = (state_q == ST_LATCH);
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
